up_bus_arbiter: RTL and testbench
=================================

Name: up_bus_arbiter

Overview:
- Shares the single external memory bus (address latch, read/write strobes, data) between two requesters: the CPU controller (port 0) and a DMA/loader engine (port 1).
- Arbitrates with 2-way round-robin and sequences each transfer as address phase, access phase, then completion.
- Provides a bounded wait on the memory ready handshake with an error indication on timeout.
- Sits between the up controller/datapath and the memory interface.

Parameters:
AW, 8, address width
DW, 8, data width
TIMEOUT, 15, maximum access-phase cycles waiting for mem_rdy before abort (1..255)

Ports:
clk  input  1  clock
nRst  input  1  reset, asynchronous, active-low
cpu_req  input  1  CPU transfer request; held until cpu_done
cpu_we  input  1  CPU write (1) / read (0)
cpu_addr  input  AW  CPU address
cpu_wdata  input  DW  CPU write data
cpu_gnt  output  1  CPU owns bus (ADDR..DONE)
cpu_done  output  1  one-cycle completion pulse to CPU
dma_req, dma_we, dma_addr, dma_wdata  input  1/1/AW/DW  same as CPU, DMA port
dma_gnt  output  1  DMA owns bus
dma_done  output  1  one-cycle completion pulse to DMA
rdata  output  DW  read data, valid while done pulses; held otherwise
err  output  1  pulses with done when transfer timed out
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data, sampled on mem_rdy
mem_ale  output  1  address latch enable
mem_re  output  1  read strobe
mem_we  output  1  write strobe
mem_rdy  input  1  memory ready, ends access phase

Behaviour:
- States: IDLE=2'b00, ADDR=2'b01, ACCESS=2'b10, DONE=2'b11. Registered state; outputs decoded from state plus registered owner/transaction regs.
- Reset (async, any state): state=IDLE, owner=CPU, last_owner=DMA (CPU wins first tie), all outputs 0, rdata=0, wait counter=0.
- IDLE: no req -> stay. Exactly one req -> that port wins. Both -> port != last_owner wins. On winning: latch we/addr/wdata of winner into internal regs, set owner, go ADDR. No strobes in IDLE.
- ADDR (1 cycle): mem_ale=1, mem_addr=latched addr, owner gnt=1 -> ACCESS; wait counter cleared.
- ACCESS: mem_addr held; mem_re=~we, mem_we=we, mem_wdata=latched wdata (0 when read). Counter increments each cycle. mem_rdy=1 -> if read, capture mem_rdata into rdata; go DONE, err_flag=0. Else if counter==TIMEOUT-1 (i.e. TIMEOUT cycles without rdy) -> go DONE, err_flag=1, rdata=0 for a timed-out read. mem_rdy on the timeout cycle counts as success.
- DONE (1 cycle): owner's done=1, err=err_flag, gnt still 1, strobes 0; last_owner=owner; -> IDLE.
- Minimum transfer: 4 cycles from req sampled in IDLE to return to IDLE. Back-to-back requests are re-arbitrated in IDLE; a continuously requesting pair alternates strictly.
- Requester dropping req mid-transfer does not abort; transfer completes and done still pulses. Changing addr/wdata after grant has no effect (latched).
- Writes leave rdata unchanged (except timeout read clears it).
- Exactly one of cpu_gnt/dma_gnt high outside IDLE; never both. mem_re and mem_we never both high.
- Counter width: 8 bits, no wrap issue since TIMEOUT<=255.

Decomposition:
- Package up_bus_pkg: state encoding constants (IDLE/ADDR/ACCESS/DONE), owner encoding (OWN_CPU=0, OWN_DMA=1).
- Sub-module up_rr_arb2: combinational 2-way round-robin pick (req[1:0], last_owner -> winner, valid). FSM, latches and timeout counter stay in up_bus_arbiter.

Test Plan:
- CPU read addr 8'h3C, mem_rdy high in first ACCESS cycle, mem_rdata=8'hA5 -> mem_ale one cycle with addr 3C, mem_re one cycle, cpu_done pulse 4 cycles after req with rdata=A5, err=0, dma signals 0.
- DMA write addr 8'h10 data 8'h77, mem_rdy delayed 3 cycles -> mem_we high 4 cycles, mem_wdata=77, dma_done once, rdata unchanged.
- Both req held after reset, 4 transfers -> grant order CPU, DMA, CPU, DMA; never both gnt high.
- CPU read with mem_rdy never asserted, TIMEOUT=15 -> mem_re high exactly 15 cycles, cpu_done with err=1, rdata=0, returns IDLE.
- nRst asserted during ACCESS of a DMA write -> strobes/gnt/done drop immediately, state IDLE; next simultaneous req after reset grants CPU.
- CPU drops req and changes cpu_addr to 8'hFF during ACCESS -> mem_addr stays original, cpu_done still pulses once.

Source files
------------

// File: rtl/up_bus_pkg.sv
// Shared encodings for the up external-bus arbiter: FSM states, bus owners,
// and the width of the access-phase wait counter.
package up_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ADDR   = 2'b01,
    ACCESS = 2'b10,
    DONE   = 2'b11
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  localparam int CNT_W = 8;

endpackage

// File: rtl/up_rr_arb2.sv
// Combinational 2-way round-robin pick: a lone requester wins, and on a tie
// the port that did not own the bus last wins.
module up_rr_arb2
  import up_bus_pkg::*;
(
  input  logic [1:0] i_req,
  input  owner_e     i_last_owner,
  output owner_e     o_winner,
  output logic       o_valid
);

  // NOTE: every output of an always_comb gets a default first, so that no
  // path through the case leaves one unassigned and a latch is inferred.
  always_comb begin
    o_valid  = |i_req;
    o_winner = OWN_CPU;
    case (i_req)
      2'b10:   o_winner = OWN_DMA;
      2'b11:   o_winner = (i_last_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
      default: o_winner = OWN_CPU;
    endcase
  end

endmodule

// File: rtl/up_bus_arbiter.sv
// Shares the external memory bus between the CPU (port 0) and the DMA engine
// (port 1): round-robin grant, ADDR/ACCESS/DONE sequencing, bounded wait.
module up_bus_arbiter
  import up_bus_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_done,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_ale,
  output logic          mem_re,
  output logic          mem_we,
  input  logic          mem_rdy
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_e           r_state;
  state_e           w_next_state;
  owner_e           r_owner;
  owner_e           r_last_owner;
  logic             r_we;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_wdata;
  logic [DW-1:0]    r_rdata;
  logic             r_err_flag;
  logic [CNT_W-1:0] r_cnt;

  owner_e           w_winner;
  logic             w_arb_valid;
  logic             w_timeout;
  logic             w_own_dma;

  up_rr_arb2 u_arb (
    .i_req        ({dma_req, cpu_req}),
    .i_last_owner (r_last_owner),
    .o_winner     (w_winner),
    .o_valid      (w_arb_valid)
  );

  assign w_timeout = (r_cnt == TMO_LAST);
  assign w_own_dma = (r_owner == OWN_DMA);
  assign rdata     = r_rdata;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    cpu_gnt      = 1'b0;
    dma_gnt      = 1'b0;
    cpu_done     = 1'b0;
    dma_done     = 1'b0;
    err          = 1'b0;
    mem_ale      = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (r_state)
      IDLE: begin
        if (w_arb_valid) w_next_state = ADDR;
      end
      ADDR: begin
        cpu_gnt      = !w_own_dma;
        dma_gnt      = w_own_dma;
        mem_ale      = 1'b1;
        mem_addr     = r_addr;
        w_next_state = ACCESS;
      end
      ACCESS: begin
        cpu_gnt   = !w_own_dma;
        dma_gnt   = w_own_dma;
        mem_addr  = r_addr;
        mem_re    = !r_we;
        mem_we    = r_we;
        mem_wdata = r_we ? r_wdata : '0;
        if (mem_rdy || w_timeout) w_next_state = DONE;
      end
      DONE: begin
        cpu_gnt      = !w_own_dma;
        dma_gnt      = w_own_dma;
        cpu_done     = !w_own_dma;
        dma_done     = w_own_dma;
        err          = r_err_flag;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_owner      <= OWN_CPU;
      r_last_owner <= OWN_DMA;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_err_flag   <= 1'b0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_arb_valid) begin
            r_owner <= w_winner;
            r_we    <= (w_winner == OWN_DMA) ? dma_we    : cpu_we;
            r_addr  <= (w_winner == OWN_DMA) ? dma_addr  : cpu_addr;
            r_wdata <= (w_winner == OWN_DMA) ? dma_wdata : cpu_wdata;
          end
        end
        ADDR: r_cnt <= '0;
        ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          // A ready on the final allowed cycle still counts as success.
          if (mem_rdy) begin
            if (!r_we) r_rdata <= mem_rdata;
            r_err_flag <= 1'b0;
          end else if (w_timeout) begin
            if (!r_we) r_rdata <= '0;
            r_err_flag <= 1'b1;
          end
        end
        DONE: r_last_owner <= r_owner;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_up_bus_arbiter.sv
// Scoreboard bench for up_bus_arbiter: directed transfers push expected
// completions; a monitor pops and compares on every done pulse.
module tb_up_bus_arbiter;

  typedef struct {
    logic       port;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       nRst;
  logic       cpu_req, cpu_we, dma_req, dma_we;
  logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic       cpu_gnt, cpu_done, dma_gnt, dma_done, err;
  logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic       mem_ale, mem_re, mem_we, mem_rdy;

  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t sb_q[$];

  int         rdy_delay, stop_at_acc;
  bit         drop_on_done, tweak_cpu;
  int         n_ale, n_re, n_we, done_cyc;
  logic [7:0] ale_addr, wd_seen, acc_addr;
  logic       ale_owner, saw_cpu_gnt, saw_dma_gnt;
  logic [7:0] own_seq;

  up_bus_arbiter #(.AW(8), .DW(8), .TIMEOUT(15)) dut (
    .clk(clk), .nRst(nRst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_done(dma_done),
    .rdata(rdata), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ale(mem_ale), .mem_re(mem_re), .mem_we(mem_we), .mem_rdy(mem_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Completion monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (cpu_done || dma_done) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL sb_unexpected_done: cpu_done=%b dma_done=%b, none expected", cpu_done, dma_done);
      end else begin
        e = sb_q.pop_front();
        check("sb_done_port", {cpu_done, dma_done}, e.port ? 32'h1 : 32'h2);
        check("sb_rdata", rdata, e.rdata);
        check("sb_err", err, e.err);
      end
    end
  end

  // Bus invariants: at most one grant, never both strobes.
  always @(negedge clk) begin
    check("inv_one_gnt", cpu_gnt & dma_gnt, 0);
    check("inv_one_strobe", mem_re & mem_we, 0);
  end

  task automatic push(input logic port, input logic [7:0] rd, input logic e);
    exp_t x;
    x.port = port; x.rdata = rd; x.err = e;
    sb_q.push_back(x);
  endtask

  // Steps negedges, plays the memory side and records bus activity until a
  // done pulse, a requested access-cycle stop, or the cycle bound.
  task automatic observe(input int max_cyc);
    int acc;
    bit fin;
    n_ale = 0; n_re = 0; n_we = 0; done_cyc = 0; acc = 0; fin = 0;
    saw_cpu_gnt = 0; saw_dma_gnt = 0;
    for (int i = 1; i <= max_cyc && !fin; i++) begin
      @(negedge clk);
      if (mem_ale) begin n_ale++; ale_addr = mem_addr; ale_owner = dma_gnt; end
      if (cpu_gnt) saw_cpu_gnt = 1;
      if (dma_gnt) saw_dma_gnt = 1;
      if (mem_re) n_re++;
      if (mem_we) begin n_we++; wd_seen = mem_wdata; end
      if (mem_re || mem_we) begin
        acc++;
        acc_addr = mem_addr;
        mem_rdy  = (acc > rdy_delay);
        if (tweak_cpu && acc == 1) begin cpu_req = 0; cpu_addr = 8'hFF; end
      end else begin
        acc = 0;
        mem_rdy = 0;
      end
      if (cpu_done || dma_done) begin
        done_cyc = i;
        fin = 1;
        if (drop_on_done) begin cpu_req = 0; dma_req = 0; end
      end
      if (stop_at_acc != 0 && acc == stop_at_acc) fin = 1;
    end
    if (!fin) begin
      n_vec++;
      n_miss++;
      $display("FAIL observe_bound: no completion within %0d cycles", max_cyc);
    end
  endtask

  initial begin
    nRst = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    mem_rdata = 0; mem_rdy = 0;
    rdy_delay = 0; stop_at_acc = 0; drop_on_done = 1; tweak_cpu = 0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {cpu_gnt, dma_gnt, cpu_done, dma_done, mem_ale, mem_re, mem_we, err}, 0);
    check("rst_rdata", rdata, 8'h00);
    nRst = 1;
    @(negedge clk);

    // CPU read, ready in the first access cycle.
    push(0, 8'hA5, 0);
    mem_rdata = 8'hA5; rdy_delay = 0;
    cpu_we = 0; cpu_addr = 8'h3C; cpu_req = 1;
    observe(20);
    check("t1_ale_count", n_ale, 1);
    check("t1_ale_addr", ale_addr, 8'h3C);
    check("t1_re_count", n_re, 1);
    check("t1_we_count", n_we, 0);
    check("t1_done_cycle", done_cyc, 3);
    check("t1_no_dma_gnt", saw_dma_gnt, 0);

    // DMA write, ready delayed three cycles; rdata must be untouched.
    @(negedge clk);
    push(1, 8'hA5, 0);
    rdy_delay = 3; mem_rdata = 8'h11;
    dma_we = 1; dma_addr = 8'h10; dma_wdata = 8'h77; dma_req = 1;
    observe(20);
    check("t2_we_count", n_we, 4);
    check("t2_wdata", wd_seen, 8'h77);
    check("t2_re_count", n_re, 0);
    check("t2_ale_addr", ale_addr, 8'h10);
    check("t2_done_cycle", done_cyc, 6);
    check("t2_no_cpu_gnt", saw_cpu_gnt, 0);

    // Both requesting continuously: strict alternation starting with CPU.
    @(negedge clk);
    rdy_delay = 0;
    cpu_we = 1; cpu_addr = 8'h01; cpu_wdata = 8'hC1;
    dma_we = 1; dma_addr = 8'h02; dma_wdata = 8'hD2;
    push(0, 8'hA5, 0); push(1, 8'hA5, 0); push(0, 8'hA5, 0); push(1, 8'hA5, 0);
    cpu_req = 1; dma_req = 1;
    own_seq = 0;
    drop_on_done = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) drop_on_done = 1;
      observe(20);
      own_seq[k] = ale_owner;
    end
    check("t3_grant_order", own_seq[3:0], 4'b1010);

    // CPU read that never sees ready: timeout after exactly 15 strobe cycles.
    @(negedge clk);
    push(0, 8'h00, 1);
    rdy_delay = 1000;
    cpu_we = 0; cpu_addr = 8'h55; cpu_req = 1;
    observe(40);
    check("t4_re_count", n_re, 15);
    @(negedge clk);
    check("t4_back_idle", {cpu_gnt, dma_gnt, mem_re, mem_we}, 0);
    check("t4_rdata_cleared", rdata, 8'h00);

    // Asynchronous reset in the middle of a DMA write's access phase.
    dma_we = 1; dma_addr = 8'h20; dma_wdata = 8'h3E; dma_req = 1;
    stop_at_acc = 2;
    observe(20);
    stop_at_acc = 0;
    check("t5_mid_access", {dma_gnt, mem_we}, 2'b11);
    #2 nRst = 0;
    #1 check("t5_rst_drop", {cpu_gnt, dma_gnt, cpu_done, dma_done, mem_ale, mem_re, mem_we}, 0);
    @(negedge clk);
    nRst = 1; dma_req = 0; mem_rdy = 0;
    @(negedge clk);
    push(0, 8'h00, 0);
    rdy_delay = 0;
    cpu_we = 1; cpu_addr = 8'h30; cpu_wdata = 8'h99; cpu_req = 1; dma_req = 1;
    observe(20);
    check("t5_first_after_rst", ale_owner, 0);

    // CPU drops req and changes address mid-access: transfer still completes.
    @(negedge clk);
    push(0, 8'h5A, 0);
    rdy_delay = 2; mem_rdata = 8'h5A; tweak_cpu = 1;
    cpu_we = 0; cpu_addr = 8'h20; cpu_req = 1;
    observe(20);
    tweak_cpu = 0;
    check("t6_ale_addr", ale_addr, 8'h20);
    check("t6_access_addr", acc_addr, 8'h20);
    check("t6_re_count", n_re, 3);
    repeat (6) @(negedge clk);
    check("t6_idle_after", {cpu_gnt, dma_gnt}, 0);
    check("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
